argmax_out: RTL and testbench
=============================

# argmax_out

Parametrised output-layer result stage for the MLP. It captures each output-neuron value as the layer writes it to its mapped address. On the rising edge of `done` it scans the captured values sequentially and reports the winning class index and its value with a one-cycle `finished` pulse. It sits after the final MLP layer and is the next generation of the single-value softmax pass-through stage: N slots, address decode, and a max search.

## Interface
Parameters:
- `DATA_W`, 16, width of neuron values
- `NUM_OUT`, 10, number of output slots/classes (>= 2)
- `ADDR_W`, 12, width of write address
- `BASE_ADDR`, 12'hC00, address of slot 0; slot k at `BASE_ADDR+k`
- `IDX_W`, `$clog2(NUM_OUT)`, width of class index (derived, not overridden)

Ports:
- `clk` in 1: single clock, all logic on posedge
- `reset` in 1: synchronous, active-high
- `wr_en` in 1: neuron write strobe
- `write_neuron_addr` in `ADDR_W`: destination address of current write
- `in` in `DATA_W`: neuron value
- `done` in 1: layer-complete level; rising edge starts a scan
- `busy` out 1: high while scanning
- `finished` out 1: one-cycle pulse, result valid
- `class_idx` out `IDX_W`: index of maximum slot
- `result` out `DATA_W`: value of maximum slot

## Operation
- Reset: all slots = 0, `prev_done`=0, state IDLE, `busy`=0, `finished`=0, `class_idx`=0, `result`=0.
- `prev_done <= done` every cycle, including during reset (reset forces 0).
- Write: in IDLE, if `wr_en` and `BASE_ADDR <= write_neuron_addr < BASE_ADDR+NUM_OUT`, then `slot[addr-BASE_ADDR] <= in`.
  - Out-of-range addresses are ignored.
  - Writes are ignored in SCAN.
  - Slots persist after a result and are never auto-cleared.
- States:
  - IDLE: `done && !prev_done` moves to SCAN with `idx`=0. A write in the same cycle is still captured.
  - SCAN: one slot per cycle.
    - `idx`=0: `best<=slot[0]`, `best_idx<=0`.
    - `idx`>0: if `slot[idx] > best`, update both registers.
    - `idx` increments until `NUM_OUT-1`.
    - The cycle with `idx`=`NUM_OUT-1` registers `result`/`class_idx` from the final comparison, pulses `finished`, and returns to IDLE.
- Compare is strict (`>`), so ties resolve to the lowest index.
- `result`/`class_idx` hold until the next `finished`.
- A `done` rising edge while in SCAN is ignored, and no rescan is queued. Holding `done` high yields exactly one result.
- Reset mid-scan: immediate return to reset values. No `finished` is produced for the aborted scan.

## Timing
- Cycle 0 = first cycle `done` is sampled high with `prev_done`=0.
- `busy` is high in cycles 1..`NUM_OUT`.
- `finished` is high in cycle `NUM_OUT+1` only, with `result`/`class_idx` valid from that cycle onward. For the default N=10 that is cycle 11.
- The earliest next scan start is the cycle `finished` is high, provided `done` falls then rises again.
- Write to result: a slot written in cycle 0 participates in that scan.

## Configuration
- `ARGMAX_SIGNED_EN`:
  - Defined: slots and comparison are two's-complement signed, matching fixed-point neuron outputs.
  - Undefined: unsigned comparison.
- Reset values and latency are identical either way.

## Test plan
- Reset, write slots 0..9 with 5,3,9,1,0,2,7,4,8,6 at 12'hC00..12'hC09, pulse `done` -> `finished` in cycle 11, `class_idx`=2, `result`=9, `busy` high cycles 1..10.
- Ties: slots 3 and 7 both = 16'h0100, others 0 -> `class_idx`=3.
- Signed (`ARGMAX_SIGNED_EN`): all slots 16'hFFxx negative except slot 5 = 16'hFFFF -> `class_idx`=5. Unsigned build with slot 0 = 16'h8000 and others 16'h7FFF -> `class_idx`=0.
- Write to 12'hC0A and 12'hBFF with 16'h7FFF, slots otherwise 1..10 -> ignored, `class_idx`=9, `result`=10. A write during SCAN is ignored.
- Hold `done` high 30 cycles and re-pulse `done` in cycle 4 of a scan -> exactly one `finished`.
- Assert `reset` in cycle 5 of a scan -> no `finished`, all outputs 0 next cycle, and a subsequent scan with no writes yields `class_idx`=0, `result`=0.

Source files
------------

// File: rtl/argmax_out_if.sv
// Write/scan/result bus for argmax_out. The layer side drives master and
// the argmax stage is the slave.
interface argmax_out_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12,
   parameter int IDX_W  = 4
);
   logic              wr_en;
   logic [ADDR_W-1:0] write_neuron_addr;
   logic [DATA_W-1:0] in;
   logic              done;
   logic              busy;
   logic              finished;
   logic [IDX_W-1:0]  class_idx;
   logic [DATA_W-1:0] result;

   modport master (
      output wr_en, write_neuron_addr, in, done,
      input  busy, finished, class_idx, result
   );

   modport slave (
      input  wr_en, write_neuron_addr, in, done,
      output busy, finished, class_idx, result
   );
endinterface

// File: rtl/argmax_out.sv
// Output-layer argmax stage: captures NUM_OUT neuron values by address and
// scans them on a rising done edge. Define ARGMAX_SIGNED_EN for signed compare.
module argmax_out #(
   parameter int                 DATA_W    = 16,
   parameter int                 NUM_OUT   = 10,
   parameter int                 ADDR_W    = 12,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = 12'hC00
) (
   input  logic       clk,
   input  logic       reset,
   argmax_out_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_OUT);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_OUT - 1);

`ifdef ARGMAX_SIGNED_EN
   typedef logic signed [DATA_W-1:0] val_t;
`else
   typedef logic [DATA_W-1:0] val_t;
`endif

   typedef enum logic {S_IDLE, S_SCAN} state_t;

   state_t           r_state;
   val_t             r_slot [NUM_OUT];
   logic             r_prev_done;
   logic [IDX_W-1:0] r_idx;
   val_t             r_best;
   logic [IDX_W-1:0] r_best_idx;
   logic             r_busy;
   logic             r_finished;
   logic [IDX_W-1:0] r_class_idx;
   val_t             r_result;

   logic [ADDR_W-1:0] w_off;
   logic              w_wr_hit;
   logic [IDX_W-1:0]  w_wr_idx;
   logic              w_start;
   val_t              w_cur;
   logic              w_gt;
   val_t              w_win_val;
   logic [IDX_W-1:0]  w_win_idx;

   // Subtract first so the decode never needs BASE_ADDR+NUM_OUT, which may wrap.
   assign w_off     = bus.write_neuron_addr - BASE_ADDR;
   assign w_wr_hit  = bus.wr_en && (bus.write_neuron_addr >= BASE_ADDR) &&
                      (w_off < ADDR_W'(NUM_OUT));
   assign w_wr_idx  = IDX_W'(w_off);
   assign w_start   = bus.done && !r_prev_done;

   assign w_cur     = r_slot[r_idx];
   assign w_gt      = w_cur > r_best;
   assign w_win_val = w_gt ? w_cur : r_best;
   assign w_win_idx = w_gt ? r_idx : r_best_idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_prev_done <= 1'b0;
         r_idx       <= '0;
         r_best      <= '0;
         r_best_idx  <= '0;
         r_busy      <= 1'b0;
         r_finished  <= 1'b0;
         r_class_idx <= '0;
         r_result    <= '0;
         for (int k = 0; k < NUM_OUT; k++) r_slot[k] <= '0;
      end else begin
         r_prev_done <= bus.done;
         r_finished  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_wr_hit) r_slot[w_wr_idx] <= val_t'(bus.in);
               if (w_start) begin
                  r_state <= S_SCAN;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_SCAN: begin
               if (r_idx == '0) begin
                  r_best     <= w_cur;
                  r_best_idx <= '0;
               end else if (w_gt) begin
                  r_best     <= w_cur;
                  r_best_idx <= r_idx;
               end
               // The last slot's comparison feeds the result directly.
               if (r_idx == LAST) begin
                  r_result    <= w_win_val;
                  r_class_idx <= w_win_idx;
                  r_finished  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.finished  = r_finished;
   assign bus.class_idx = r_class_idx;
   assign bus.result    = DATA_W'(r_result);
endmodule

// File: tb/tb_argmax_out.sv
// Scoreboard bench for argmax_out: scans push expected results, a negedge
// monitor pops and checks them whenever finished is seen.
module tb_argmax_out;
   localparam int DATA_W = 16;
   localparam int NUM_OUT = 10;
   localparam int ADDR_W = 12;
   localparam int IDX_W = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   ntests = 0;
   int   nfail = 0;

   typedef struct {
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] res;
      int                cyc;
   } exp_t;
   exp_t q[$];

   argmax_out_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

   argmax_out #(.DATA_W(DATA_W), .NUM_OUT(NUM_OUT), .ADDR_W(ADDR_W),
                .BASE_ADDR(12'hC00)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.finished) begin
         if (q.size() == 0) begin
            ntests++; nfail++;
            $display("FAIL unexpected_finished at cyc %0d idx=%0d res=%h", cyc, bus.class_idx, bus.result);
         end else begin
            exp_t e;
            e = q.pop_front();
            ntests++;
            if (bus.class_idx !== e.idx) begin
               nfail++; $display("FAIL class_idx got %0d want %0d", bus.class_idx, e.idx);
            end
            ntests++;
            if (bus.result !== e.res) begin
               nfail++; $display("FAIL result got %h want %h", bus.result, e.res);
            end
            ntests++;
            if (cyc != e.cyc) begin
               nfail++; $display("FAIL finish_cycle got %0d want %0d", cyc, e.cyc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      ntests++;
      if (got !== want) begin
         nfail++; $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus.wr_en = 1'b1; bus.write_neuron_addr = a; bus.in = d;
      tick();
      bus.wr_en = 1'b0;
   endtask

   task automatic load(input logic [DATA_W-1:0] v [NUM_OUT]);
      for (int k = 0; k < NUM_OUT; k++) wr(12'hC00 + 12'(k), v[k]);
   endtask

   // Pulses done in cycle 0, optionally re-pulses in cycle 4 and writes mid-scan.
   task automatic scan(input logic [IDX_W-1:0] ei, input logic [DATA_W-1:0] er,
                       input bit chk_busy, input bit repulse, input bit wr_mid);
      int start;
      exp_t e;
      start = cyc;
      e.idx = ei; e.res = er; e.cyc = start + NUM_OUT + 1;
      q.push_back(e);
      bus.done = 1'b1;
      for (int k = 0; k <= NUM_OUT + 2; k++) begin
         @(negedge clk);
         if (chk_busy) check($sformatf("busy_c%0d", k), 32'(bus.busy), 32'(k >= 1 && k <= NUM_OUT));
         tick();
         bus.wr_en = 1'b0;
         if (k == 0) bus.done = 1'b0;
         if (repulse && k == 3) bus.done = 1'b1;
         if (repulse && k == 4) bus.done = 1'b0;
         if (wr_mid && k == 2) begin
            bus.wr_en = 1'b1; bus.write_neuron_addr = 12'hC00; bus.in = 16'h7FFF;
         end
      end
      check("queue_drained", 32'(q.size()), 32'd0);
   endtask

   logic [DATA_W-1:0] v [NUM_OUT];

   initial begin
      int start;
      exp_t e;
      bus.wr_en = 1'b0; bus.write_neuron_addr = '0; bus.in = '0; bus.done = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_finished", 32'(bus.finished), 32'd0);
      check("rst_class_idx", 32'(bus.class_idx), 32'd0);
      check("rst_result", 32'(bus.result), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      // basic vector
      v = '{16'd5, 16'd3, 16'd9, 16'd1, 16'd0, 16'd2, 16'd7, 16'd4, 16'd8, 16'd6};
      load(v);
      scan(4'd2, 16'd9, 1'b1, 1'b0, 1'b0);

      // ties resolve to lowest index
      v = '{default: 16'h0000};
      v[3] = 16'h0100; v[7] = 16'h0100;
      load(v);
      scan(4'd3, 16'h0100, 1'b0, 1'b0, 1'b0);

      // negative values, slot 5 is max in either build
      for (int k = 0; k < NUM_OUT; k++) v[k] = 16'hFF00 + 16'(k);
      v[5] = 16'hFFFF;
      load(v);
      scan(4'd5, 16'hFFFF, 1'b0, 1'b0, 1'b0);

      // sign boundary
      v = '{default: 16'h7FFF};
      v[0] = 16'h8000;
      load(v);
`ifdef ARGMAX_SIGNED_EN
      scan(4'd1, 16'h7FFF, 1'b0, 1'b0, 1'b0);
`else
      scan(4'd0, 16'h8000, 1'b0, 1'b0, 1'b0);
`endif

      // out-of-range writes ignored, then a mid-scan write ignored
      for (int k = 0; k < NUM_OUT; k++) v[k] = 16'(k + 1);
      load(v);
      wr(12'hC0A, 16'h7FFF);
      wr(12'hBFF, 16'h7FFF);
      scan(4'd9, 16'd10, 1'b0, 1'b0, 1'b1);
      scan(4'd9, 16'd10, 1'b0, 1'b0, 1'b0);

      // rising edge during scan ignored
      scan(4'd9, 16'd10, 1'b0, 1'b1, 1'b0);

      // done held high for 30 cycles gives one result
      start = cyc;
      e.idx = 4'd9; e.res = 16'd10; e.cyc = start + NUM_OUT + 1;
      q.push_back(e);
      bus.done = 1'b1;
      repeat (30) tick();
      bus.done = 1'b0;
      repeat (3) tick();
      check("hold_queue_drained", 32'(q.size()), 32'd0);

      // reset in cycle 5 aborts the scan
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      repeat (4) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_finished", 32'(bus.finished), 32'd0);
      check("abort_class_idx", 32'(bus.class_idx), 32'd0);
      check("abort_result", 32'(bus.result), 32'd0);
      tick();
      repeat (15) tick();
      scan(4'd0, 16'd0, 1'b0, 1'b0, 1'b0);

      repeat (3) tick();
      check("final_queue_empty", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout at cyc %0d", cyc);
      $fatal(1, "timeout");
   end
endmodule
